// File: rtl/async_fifo_b.sv
// async_fifo_b: single-clock FIFO that keeps the AsyncFifoB io_ port naming.
// Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits. Pointers are binary with one
// extra wrap bit, so full and empty can be told apart when the low bits match.
//
// Ports:
//   io_clk    - clock; all state updates on its rising edge
//   io_nrst   - asynchronous, active-low reset
//   io_wr_en  - write request, accepted when not full
//   io_wdata  - write data, sampled with io_wr_en
//   io_rd_en  - read request, accepted when not empty
//   io_rdata  - registered read data, held until the next accepted read
//   io_empty  - FIFO holds no entries
//   io_full   - FIFO holds 2**ADDR_WIDTH entries
//   io_count  - occupancy, 0..2**ADDR_WIDTH (only with ASYNC_FIFO_B_COUNT_EN)
//
// Optional feature macro: ASYNC_FIFO_B_COUNT_EN adds the io_count output.
module async_fifo_b #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  io_clk,
  input  logic                  io_nrst,
  input  logic                  io_wr_en,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  input  logic                  io_rd_en,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic                  io_empty,
`ifdef ASYNC_FIFO_B_COUNT_EN
  output logic                  io_full,
  output logic [ADDR_WIDTH:0]   io_count
`else
  output logic                  io_full
`endif
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PtrOne = 1;

  logic [ADDR_WIDTH:0]   wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [Depth];
  logic                  wr_accept, rd_accept;

  // Flags decode registered pointers only; no input reaches them combinationally.
  assign io_empty = (wr_ptr_q == rd_ptr_q);
  assign io_full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  assign wr_accept = io_wr_en & ~io_full;
  assign rd_accept = io_rd_en & ~io_empty;

  always_ff @(posedge io_clk or negedge io_nrst) begin
    if (!io_nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_accept) begin
        rdata_q  <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Storage is not reset; the io_nrst term keeps writes out while reset is held.
  always_ff @(posedge io_clk) begin
    if (wr_accept && io_nrst) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= io_wdata;
    end
  end

  assign io_rdata = rdata_q;

`ifdef ASYNC_FIFO_B_COUNT_EN
  // Modular difference gives 0..Depth thanks to the wrap bit.
  assign io_count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_async_fifo_b.sv
// Self-checking bench for async_fifo_b. The monitor keeps a scoreboard queue of
// words the FIFO should hold: accepted writes push, accepted reads pop into the
// expected read data. Flags, read data (and count) are compared after every edge.
module tb_async_fifo_b;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          io_clk = 1'b0;
  logic          io_nrst = 1'b0;
  logic          io_wr_en = 1'b0;
  logic [DW-1:0] io_wdata = '0;
  logic          io_rd_en = 1'b0;
  logic [DW-1:0] io_rdata;
  logic          io_empty;
  logic          io_full;
`ifdef ASYNC_FIFO_B_COUNT_EN
  logic [AW:0]   io_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_rdata = '0;

  async_fifo_b #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .io_clk  (io_clk),
    .io_nrst (io_nrst),
    .io_wr_en(io_wr_en),
    .io_wdata(io_wdata),
    .io_rd_en(io_rd_en),
    .io_rdata(io_rdata),
    .io_empty(io_empty),
`ifdef ASYNC_FIFO_B_COUNT_EN
    .io_full (io_full),
    .io_count(io_count)
`else
    .io_full (io_full)
`endif
  );

  always #5 io_clk = ~io_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reset clears the model the moment it asserts.
  always @(negedge io_nrst) begin
    sb.delete();
    exp_rdata = '0;
  end

  // Monitor: acceptance is decided from the model occupancy before the edge.
  always @(posedge io_clk) begin
    logic          wacc, racc;
    logic [DW-1:0] wd;
    wd   = io_wdata;
    wacc = io_nrst && io_wr_en && (sb.size() < DEPTH);
    racc = io_nrst && io_rd_en && (sb.size() > 0);
    if (!io_nrst) begin
      sb.delete();
      exp_rdata = '0;
    end
    if (racc) exp_rdata = sb.pop_front();
    if (wacc) sb.push_back(wd);
    #1;
    check("mon_rdata", 32'(io_rdata), 32'(exp_rdata));
    check("mon_empty", 32'(io_empty), 32'(sb.size() == 0));
    check("mon_full", 32'(io_full), 32'(sb.size() == DEPTH));
`ifdef ASYNC_FIFO_B_COUNT_EN
    check("mon_count", 32'(io_count), 32'(sb.size()));
`endif
  end

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
    @(negedge io_clk);
    io_wr_en = w;
    io_wdata = d;
    io_rd_en = r;
  endtask

  // Wait for the edge that consumes the current drive, then settle.
  task automatic settle();
    @(posedge io_clk);
    #2;
  endtask

  initial begin
    int wr_cnt, rd_cnt, cycles;

    // Reset held with both requests active: nothing may be accepted.
    io_wr_en = 1'b1;
    io_wdata = 8'h33;
    io_rd_en = 1'b1;
    repeat (3) @(posedge io_clk);
    #2;
    check("rst_empty", 32'(io_empty), 32'd1);
    check("rst_full", 32'(io_full), 32'd0);
    check("rst_rdata", 32'(io_rdata), 32'h0);
    drive(1'b0, 8'h00, 1'b0);
    io_nrst = 1'b1;
    settle();
    check("rst_release_empty", 32'(io_empty), 32'd1);

    // Fill 0x00..0x0F, then overfill with 0xAA.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0);
    settle();
    check("fill_full", 32'(io_full), 32'd1);
    drive(1'b1, 8'hAA, 1'b0);
    settle();
    check("overfill_full", 32'(io_full), 32'd1);

    // Drain; monitor checks the 0x00..0x0F order.
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'h00, 1'b1);
    settle();
    check("drain_last", 32'(io_rdata), 32'h0F);
    check("drain_empty", 32'(io_empty), 32'd1);

    // Read while empty holds the last word.
    drive(1'b0, 8'h00, 1'b1);
    settle();
    check("empty_read_hold", 32'(io_rdata), 32'h0F);
    check("empty_read_empty", 32'(io_empty), 32'd1);

    // Simultaneous access when full: read wins, 0x55 dropped.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
    drive(1'b1, 8'h55, 1'b1);
    settle();
    check("simfull_rdata", 32'(io_rdata), 32'h10);
    check("simfull_full", 32'(io_full), 32'd0);
`ifdef ASYNC_FIFO_B_COUNT_EN
    check("simfull_count", 32'(io_count), 32'd15);
`endif
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 8'h00, 1'b1);
    settle();
    check("simfull_drain_last", 32'(io_rdata), 32'h1F);
    check("simfull_drain_empty", 32'(io_empty), 32'd1);

    // Simultaneous access when empty: write wins, rdata unchanged.
    drive(1'b1, 8'h55, 1'b1);
    settle();
    check("simempty_rdata", 32'(io_rdata), 32'h1F);
    check("simempty_empty", 32'(io_empty), 32'd0);
    drive(1'b0, 8'h00, 1'b1);
    settle();
    check("simempty_read", 32'(io_rdata), 32'h55);

    // Streaming: 100 random words across many pointer wraps.
    wr_cnt = 0;
    rd_cnt = 0;
    cycles = 0;
    while ((wr_cnt < 100 || !io_empty) && cycles < 3000) begin
      @(negedge io_clk);
      io_wr_en = (wr_cnt < 100) && !io_full && ($urandom_range(0, 3) != 0);
      io_wdata = 8'($urandom);
      io_rd_en = !io_empty && ($urandom_range(0, 2) != 0);
      if (io_wr_en) wr_cnt++;
      if (io_rd_en) rd_cnt++;
      cycles++;
    end
    drive(1'b0, 8'h00, 1'b0);
    settle();
    check("stream_timeout", 32'(cycles < 3000), 32'd1);
    check("stream_writes", 32'(wr_cnt), 32'd100);
    check("stream_reads", 32'(rd_cnt), 32'd100);
    check("stream_empty", 32'(io_empty), 32'd1);

    // Async reset mid-stream with 7 entries and nonzero rdata.
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    settle();
    check("prerst_rdata", 32'(io_rdata), 32'hC0);
`ifdef ASYNC_FIFO_B_COUNT_EN
    check("prerst_count", 32'(io_count), 32'd7);
`endif
    drive(1'b0, 8'h00, 1'b0);
    #1 io_nrst = 1'b0;
    #1;
    check("midrst_empty", 32'(io_empty), 32'd1);
    check("midrst_full", 32'(io_full), 32'd0);
    check("midrst_rdata", 32'(io_rdata), 32'h0);
`ifdef ASYNC_FIFO_B_COUNT_EN
    check("midrst_count", 32'(io_count), 32'd0);
`endif
    #1 io_nrst = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    settle();
    check("postrst_read", 32'(io_rdata), 32'h77);
    drive(1'b0, 8'h00, 1'b0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
